// File: rtl/crc_engine.sv
// crc_engine: parametrised multi-bit-per-cycle CRC coprocessor.
// A start/busy/done engine that absorbs one DATA_W word per transaction, BPC bits per
// clock, using a non-reflected direct (non-augmented) CRC. Words can be chained into
// one message by starting with chain_i=1, which continues from the held register.
module crc_engine #(
   parameter int unsigned       CRC_W     = 8,
   parameter logic [CRC_W-1:0]  POLY      = 8'h07,
   parameter int unsigned       DATA_W    = 16,
   parameter int unsigned       BPC       = 1,
   parameter bit                LSB_FIRST = 1'b0,
   parameter logic [CRC_W-1:0]  XOR_OUT   = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              chain_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [CRC_W-1:0]  init_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [CRC_W-1:0]  crc_o
);

   localparam int unsigned STEPS = DATA_W / BPC;
   localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   if ((BPC == 0) || (DATA_W % BPC != 0)) begin : g_bad_bpc
      $error("crc_engine: BPC must divide DATA_W");
   end
   if ((CRC_W < 2) || (CRC_W > 32)) begin : g_bad_crc_w
      $error("crc_engine: CRC_W must be in 2..32");
   end

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e             r_state;
   state_e             w_state_next;
   logic [CRC_W-1:0]   r_crc;
   logic [CRC_W-1:0]   w_crc_next;
   logic [DATA_W-1:0]  r_shift;
   logic [DATA_W-1:0]  w_shift_next;
   logic [CNT_W-1:0]   r_cnt;
   logic               w_last;

   assign w_last = (r_cnt == CNT_W'(STEPS - 1));

   // State register with synchronous reset; reset also aborts a running transaction.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: start is only honoured in idle, so it never queues.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (start_i) w_state_next = StCalc;
         StCalc:  if (w_last)  w_state_next = StDone;
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Outputs decoded from state; crc_o is combinational from the register.
   always_comb begin
      busy_o = (r_state == StCalc);
      done_o = (r_state == StDone);
      crc_o  = r_crc ^ XOR_OUT;
   end

   // BPC chained single-bit CRC iterations in one cycle, taking bits in feed order.
   always_comb begin
      logic [CRC_W-1:0] v_crc;
      logic             v_bit;
      logic             v_fb;
      v_crc = r_crc;
      for (int i = 0; i < BPC; i++) begin
         v_bit = LSB_FIRST ? r_shift[i] : r_shift[DATA_W-1-i];
         v_fb  = v_crc[CRC_W-1] ^ v_bit;
         v_crc = {v_crc[CRC_W-2:0], 1'b0} ^ (v_fb ? POLY : '0);
      end
      w_crc_next   = v_crc;
      w_shift_next = LSB_FIRST ? (r_shift >> BPC) : (r_shift << BPC);
   end

   // Datapath: capture on accepted start, advance in CALC, hold otherwise (enables chaining).
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_crc   <= init_i;
         r_shift <= '0;
         r_cnt   <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (start_i) begin
                  r_shift <= data_i;
                  r_cnt   <= '0;
                  if (!chain_i) r_crc <= init_i;
               end
            end
            StCalc: begin
               r_crc   <= w_crc_next;
               r_shift <= w_shift_next;
               r_cnt   <= r_cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_crc_engine.sv
// Self-checking bench for crc_engine: several parameterisations driven in parallel,
// expected results from a polynomial long-division reference model via per-instance queues.
module tb_crc_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        rst_ab;
   logic [3:0]  start_a;
   logic        chain_a;
   logic [15:0] data_a;
   logic [15:0] data_l;
   logic [7:0]  init_a;
   logic        start_b;
   logic        chain_b;
   logic [7:0]  data_b;
   logic [7:0]  init_b;

   logic        busy [6];
   logic        done [6];
   logic [7:0]  crc  [6];

   // 0:BPC1 1:BPC4 2:BPC16 3:LSB-first 4:DATA_W8 5:DATA_W8 XOR 0x55
   int          steps [6] = '{16, 4, 1, 16, 8, 8};
   logic [7:0]  exp_q [6][$];
   int          bcnt  [6];
   logic        pdone [6];
   int          checks = 0;
   int          errors = 0;
   logic        mon_en = 1'b0;
   logic [7:0]  raw_a;
   logic [7:0]  raw_b;

   function automatic logic [15:0] rev16(input logic [15:0] x);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) r[i] = x[15-i];
      return r;
   endfunction

   assign data_l = rev16(data_a);

   // Reference: (seed * x^n + msg * x^8) mod (x^8 + x^2 + x + 1), by long division.
   function automatic logic [7:0] ref_crc(input logic [7:0] seed, input logic [15:0] msg,
                                          input int n);
      logic [63:0] v;
      v = ({56'd0, seed} << n) ^ ({48'd0, msg} << 8);
      for (int b = n + 7; b >= 8; b--) begin
         if (v[b]) v = v ^ (64'h107 << (b - 8));
      end
      return v[7:0];
   endfunction

   crc_engine u_bpc1 (
      .clk_i(clk), .rst_i(rst | rst_ab), .start_i(start_a[0]), .chain_i(chain_a),
      .data_i(data_a), .init_i(init_a), .busy_o(busy[0]), .done_o(done[0]), .crc_o(crc[0])
   );
   crc_engine #(.BPC(4)) u_bpc4 (
      .clk_i(clk), .rst_i(rst), .start_i(start_a[1]), .chain_i(chain_a),
      .data_i(data_a), .init_i(init_a), .busy_o(busy[1]), .done_o(done[1]), .crc_o(crc[1])
   );
   crc_engine #(.BPC(16)) u_bpc16 (
      .clk_i(clk), .rst_i(rst), .start_i(start_a[2]), .chain_i(chain_a),
      .data_i(data_a), .init_i(init_a), .busy_o(busy[2]), .done_o(done[2]), .crc_o(crc[2])
   );
   crc_engine #(.LSB_FIRST(1'b1)) u_lsb (
      .clk_i(clk), .rst_i(rst), .start_i(start_a[3]), .chain_i(chain_a),
      .data_i(data_l), .init_i(init_a), .busy_o(busy[3]), .done_o(done[3]), .crc_o(crc[3])
   );
   crc_engine #(.DATA_W(8)) u_w8 (
      .clk_i(clk), .rst_i(rst), .start_i(start_b), .chain_i(chain_b),
      .data_i(data_b), .init_i(init_b), .busy_o(busy[4]), .done_o(done[4]), .crc_o(crc[4])
   );
   crc_engine #(.DATA_W(8), .XOR_OUT(8'h55)) u_w8x (
      .clk_i(clk), .rst_i(rst), .start_i(start_b), .chain_i(chain_b),
      .data_i(data_b), .init_i(init_b), .busy_o(busy[5]), .done_o(done[5]), .crc_o(crc[5])
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the expected result on each done pulse and checks busy length.
   always @(negedge clk) begin
      logic [7:0] e;
      if (mon_en) begin
         for (int k = 0; k < 6; k++) begin
            if (done[k]) begin
               checks++;
               if (exp_q[k].size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_done inst=%0d actual=1 required=0", k);
               end else begin
                  e = exp_q[k].pop_front();
                  checks++;
                  if (crc[k] !== e) begin
                     errors++;
                     $display("FAIL crc inst=%0d actual=%0h required=%0h", k, crc[k], e);
                  end
               end
               checks++;
               if (bcnt[k] != steps[k] || busy[k] || pdone[k]) begin
                  errors++;
                  $display("FAIL latency inst=%0d actual=%0d required=%0d", k, bcnt[k],
                           steps[k]);
               end
            end
            bcnt[k]  = busy[k] ? bcnt[k] + 1 : 0;
            pdone[k] = done[k];
         end
      end
   end

   function automatic bit pending();
      for (int k = 0; k < 6; k++) if (exp_q[k].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drain();
      int t = 0;
      while (pending() && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d required=<200", t);
         for (int k = 0; k < 6; k++) exp_q[k].delete();
      end
      @(posedge clk);
   endtask

   task automatic issue_a(input logic chain, input logic [7:0] init, input logic [15:0] data,
                          input logic [3:0] mask, input bit use_k, input logic [7:0] kval);
      logic [7:0] e;
      @(posedge clk);
      #1;
      start_a = 4'hF;
      chain_a = chain;
      init_a  = init;
      data_a  = data;
      e = use_k ? kval : ref_crc(chain ? raw_a : init, data, 16);
      raw_a = e;
      for (int k = 0; k < 4; k++) if (mask[k]) exp_q[k].push_back(e);
      @(posedge clk);
      #1;
      start_a = 4'h0;
   endtask

   task automatic issue_b(input logic chain, input logic [7:0] init, input logic [7:0] data,
                          input bit use_k, input logic [7:0] kval);
      logic [7:0] e;
      @(posedge clk);
      #1;
      start_b = 1'b1;
      chain_b = chain;
      init_b  = init;
      data_b  = data;
      e = use_k ? kval : ref_crc(chain ? raw_b : init, {8'd0, data}, 8);
      raw_b = e;
      exp_q[4].push_back(e);
      exp_q[5].push_back(e ^ 8'h55);
      @(posedge clk);
      #1;
      start_b = 1'b0;
   endtask

   initial begin
      logic [7:0]  e;
      logic [7:0]  msg [9];
      rst = 1'b1; rst_ab = 1'b0;
      start_a = '0; chain_a = 0; data_a = '0; init_a = 8'h5A;
      start_b = 0;  chain_b = 0; data_b = '0; init_b = 8'h5A;
      for (int k = 0; k < 6; k++) begin bcnt[k] = 0; pdone[k] = 0; end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("reset_crc%0d", k), {8'd0, crc[k]}, (k == 5) ? 16'h0F : 16'h5A);
         check($sformatf("reset_busy%0d", k), {15'd0, busy[k]}, 16'd0);
         check($sformatf("reset_done%0d", k), {15'd0, done[k]}, 16'd0);
      end
      mon_en = 1'b1;

      // Known vectors; LSB-first instance sees the bit-reversed word.
      issue_a(1'b0, 8'h00, 16'h0001, 4'hF, 1'b1, 8'h07); drain();
      issue_a(1'b0, 8'h00, 16'h0100, 4'hF, 1'b1, 8'h15); drain();
      issue_a(1'b0, 8'h00, 16'h00FF, 4'hF, 1'b1, 8'hF3); drain();

      // "123456789" as nine chained bytes.
      for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
      for (int i = 0; i < 9; i++) begin
         issue_b(i != 0, 8'h00, msg[i], i == 8, 8'hF4);
         drain();
      end

      // Randomised transactions with chaining across idle gaps.
      for (int i = 0; i < 30; i++) begin
         issue_a((i != 0) && ($urandom_range(0, 1) == 1), 8'($urandom), 16'($urandom),
                 4'hF, 1'b0, 8'h00);
         drain();
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      for (int i = 0; i < 20; i++) begin
         issue_b((i != 0) && ($urandom_range(0, 1) == 1), 8'($urandom), 8'($urandom),
                 1'b0, 8'h00);
         drain();
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      // Start held through busy and done with changing data: only the first word counts.
      for (int r = 0; r < 3; r++) begin
         @(posedge clk);
         #1;
         start_a = 4'hF; chain_a = 1'b0; init_a = 8'($urandom); data_a = 16'($urandom);
         e = ref_crc(init_a, data_a, 16);
         raw_a = e;
         for (int k = 0; k < 4; k++) exp_q[k].push_back(e);
         for (int j = 1; j <= 18; j++) begin
            @(posedge clk);
            #1;
            data_a = 16'($urandom); init_a = 8'($urandom); chain_a = 1'($urandom);
            for (int k = 0; k < 4; k++) start_a[k] = (j <= steps[k] + 1);
         end
         drain();
      end

      // Reset at CALC cycle 5 of the BPC=1 instance only.
      issue_a(1'b0, 8'h00, 16'($urandom), 4'b1110, 1'b0, 8'h00);
      repeat (4) @(posedge clk);
      #1;
      init_a = 8'hFF;
      rst_ab = 1'b1;
      @(posedge clk);
      #1;
      rst_ab = 1'b0;
      @(negedge clk);
      check("abort_busy", {15'd0, busy[0]}, 16'd0);
      check("abort_crc", {8'd0, crc[0]}, 16'h00FF);
      drain();
      repeat (20) @(posedge clk);
      issue_a(1'b0, 8'h00, 16'h0001, 4'hF, 1'b1, 8'h07); drain();

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
